// File: rtl/change_dispense_ctrl.sv
// Change dispenser: pays a cents amount one coin at a time, largest
// denomination first, from a per-denomination coin inventory. Reports any
// unpaid remainder as shortfall and flags a hopper that never acknowledges.
module change_dispense_ctrl #(
    parameter int AMT_W       = 10,
    parameter int CNT_W       = 6,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] changeAmt,
    input  logic [3:0]       coinIn,
    input  logic             refill,
    input  logic [CNT_W-1:0] refillCnt,
    input  logic             ejectAck,
    output logic             busy,
    output logic [3:0]       ejectCoin,
    output logic             done,
    output logic [AMT_W-1:0] shortfall,
    output logic             fault,
    output logic [CNT_W-1:0] invDollar,
    output logic [CNT_W-1:0] invQuarter,
    output logic [CNT_W-1:0] invDime,
    output logic [CNT_W-1:0] invNickel
);
    localparam int TMR_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SELECT, EJECT, RELEASE, DONE} state_t;

    state_t                  state;
    logic [AMT_W-1:0]        remaining;
    logic [AMT_W-1:0]        curVal;
    logic [TMR_W-1:0]        timer;
    // Index 0 nickel, 1 dime, 2 quarter, 3 dollar (matches one-hot bit order)
    logic [3:0][CNT_W-1:0]   inv;
    logic [3:0]              pickOh;
    logic [AMT_W-1:0]        pickVal;
    logic                    dispense;
    logic                    coinValid;
    logic                    refillNow;

    // Saturating increment for inventory counters
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign dispense  = (state == EJECT) && ejectAck;
    assign coinValid = (coinIn != 4'd0) && ((coinIn & (coinIn - 4'd1)) == 4'd0);
    assign refillNow = refill && (state == IDLE);

    assign invNickel  = inv[0];
    assign invDime    = inv[1];
    assign invQuarter = inv[2];
    assign invDollar  = inv[3];

    // Greedy choice: largest coin that fits the remainder and is in stock
    always_comb begin
        pickOh  = 4'b0000;
        pickVal = '0;
        if (remaining >= AMT_W'(100) && inv[3] != '0) begin
            pickOh  = 4'b1000;
            pickVal = AMT_W'(100);
        end else if (remaining >= AMT_W'(25) && inv[2] != '0) begin
            pickOh  = 4'b0100;
            pickVal = AMT_W'(25);
        end else if (remaining >= AMT_W'(10) && inv[1] != '0) begin
            pickOh  = 4'b0010;
            pickVal = AMT_W'(10);
        end else if (remaining >= AMT_W'(5) && inv[0] != '0) begin
            pickOh  = 4'b0001;
            pickVal = AMT_W'(5);
        end
    end

    // Transaction sequencer with registered hopper/status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            curVal    <= '0;
            timer     <= '0;
            busy      <= 1'b0;
            ejectCoin <= 4'b0000;
            done      <= 1'b0;
            shortfall <= '0;
            fault     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= changeAmt;
                        shortfall <= '0;
                        fault     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SELECT;
                    end
                end
                SELECT: begin
                    if (pickOh != 4'b0000) begin
                        ejectCoin <= pickOh;
                        curVal    <= pickVal;
                        timer     <= '0;
                        state     <= EJECT;
                    end else begin
                        shortfall <= remaining;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                EJECT: begin
                    if (ejectAck) begin
                        remaining <= remaining - curVal;
                        ejectCoin <= 4'b0000;
                        state     <= RELEASE;
                    end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
                        // Hopper never answered: give up, owe the whole remainder
                        ejectCoin <= 4'b0000;
                        fault     <= 1'b1;
                        shortfall <= remaining;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RELEASE: begin
                    // A level ack must drop before the next coin is requested
                    if (!ejectAck) state <= SELECT;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Inventory: refill, accepted coins in, dispensed coins out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (refillNow) begin
                    inv[i] <= refillCnt;
                end else if (coinValid && coinIn[i] && !(dispense && ejectCoin[i])) begin
                    inv[i] <= satInc(inv[i]);
                end else if (dispense && ejectCoin[i] && !(coinValid && coinIn[i])) begin
                    inv[i] <= inv[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/change_dispense_ctrl.md
# change_dispense_ctrl

Sequences coin-return hardware when the vending machine owes change, after a purchase or a cancelReset refund. Takes a change amount in cents and drives a one-hot eject request to the coin hopper, one coin at a time, always choosing the largest available denomination. Tracks per-denomination coin inventory and reports any shortfall it cannot pay. Sits between the vending_machine credit logic and the coin hopper driver; its inventory counts also feed num_to_coins display logic.

## Interface
- AMT_W, 10: width of change amount in cents (max 1023).
- CNT_W, 6: width of each inventory counter; saturates at 2^CNT_W-1.
- ACK_TIMEOUT, 255: cycles to wait for ejectAck before faulting; must be ≥1.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- changeAmt  in  AMT_W  cents owed; sampled with start.
- coinIn  in  4  one-hot accepted-coin pulse {dollar,quarter,dime,nickel}; increments inventory.
- refill  in  1  load all four counters with refillCnt; honoured only in IDLE.
- refillCnt  in  CNT_W  refill value.
- ejectAck  in  1  hopper confirms the requested coin has dropped (level).
- busy  out  1  high in every state except IDLE.
- ejectCoin  out  4  one-hot request {dollar,quarter,dime,nickel}; registered.
- done  out  1  one-cycle pulse at end of transaction.
- shortfall  out  AMT_W  cents not paid; valid with done, held until next start.
- fault  out  1  set with done on ack timeout; held until next start.
- invDollar, invQuarter, invDime, invNickel  out  CNT_W each  current inventory.

## Operation
- Coin values: dollar 100, quarter 25, dime 10, nickel 5.
- States: IDLE, SELECT, EJECT, RELEASE, DONE.
- IDLE: start=1 → remaining ← changeAmt, shortfall ← 0, fault ← 0, go SELECT. start while busy ignored.
- SELECT: pick highest denomination with value ≤ remaining and count > 0. Found → EJECT with ejectCoin = that one-hot. None, or remaining = 0 → DONE.
- EJECT: hold ejectCoin. On ejectAck=1: remaining −= value, count −= 1, ejectCoin ← 0, go RELEASE. Timer reaching ACK_TIMEOUT without ack → ejectCoin ← 0, fault ← 1, DONE.
- RELEASE: wait for ejectAck=0 (no timeout), then SELECT. This prevents a held ack from counting twice.
- DONE: done=1 for one cycle, shortfall ← remaining, go IDLE.
- Amounts that are not a multiple of 5 leave remainder (1–4 cents) as shortfall.
- Inventory arithmetic:
  - coinIn increments the selected counter, saturating.
  - Simultaneous coinIn and dispense on the same denomination → count unchanged.
  - coinIn with more than one bit set is ignored entirely.
  - Dispense never occurs when count is 0, because SELECT guards it.
- refill outside IDLE is ignored. refill and coinIn in the same IDLE cycle → refill wins.

## Timing
- Reset:
  - State IDLE.
  - busy=0, ejectCoin=0, done=0, fault=0, shortfall=0.
  - All four inventory counters = 0, remaining = 0, timer = 0.
- Cycle sequence:
  - start sampled at edge N.
  - SELECT during N+1.
  - ejectCoin valid from edge N+2.
- ejectAck sampled at edge M → ejectCoin low and count decremented from M+1. Next coin earliest at the edge after ack is seen low, +1 cycle for SELECT.
- Zero-amount or zero-inventory request: done at N+2, busy high for exactly 2 cycles.
- Timer clears on entry to EJECT. Fault fires on the ACK_TIMEOUT-th cycle in EJECT without ack.
- Reset mid-transaction: immediate return to reset values. Inventory is also cleared, so the system must refill after reset.

## Test plan
- Reset, refill with refillCnt=2, start changeAmt=140.
  - Eject sequence: dollar, quarter, dime, nickel, each acked after 3 cycles.
  - done with shortfall=0.
  - Inventory ends at 1/1/1/1.
- Refill 2, then drain quarters with two start changeAmt=25 transactions, then start changeAmt=60.
  - Ejects dime, dime, nickel, nickel.
  - shortfall=30.
- Refill 2, start changeAmt=7.
  - One nickel ejected.
  - shortfall=2.
- Set ACK_TIMEOUT=8, refill 1, start changeAmt=5, never ack.
  - ejectCoin=0001 for exactly 8 cycles.
  - done with fault=1, shortfall=5.
  - invNickel remains 1.
- Hold ejectAck high for 10 cycles on the first coin of changeAmt=10 (refill 2).
  - Exactly one dime dispensed.
  - No second request until ack drops.
  - shortfall=0.
- During EJECT for a nickel, pulse coinIn=0001 in the same cycle as ejectAck.
  - invNickel unchanged.
- Assert reset mid-EJECT.
  - All outputs return to reset values on the next evaluation.
  - Inventory reads 0.
